rank_topk_engine: RTL

- Iteration and convergence controller plus sequential top-K ranker for the PageRank array.
- Watches the M node values produced by the ant cluster, one WIDTH-bit value per node.
- Ends the update phase when values converge or when an iteration cap is reached, whichever comes first.
- Then insertion-sorts all nodes into a K-entry descending list with node IDs. Generalises the fixed 400-cycle timer and fixed 64-node top-10 sorter.

---
 rtl/rank_topk_engine.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/rank_topk_engine.sv
`default_nettype none
// ============================================================================
// Module      : rank_topk_engine
// Description : PageRank iteration/convergence controller followed by a
//               sequential insertion sort that keeps the K largest node
//               values (descending) together with their node IDs.
// Revision    : 1.0 - initial release
// ============================================================================
module rank_topk_engine #(
    parameter int M        = 64,
    parameter int WIDTH    = 16,
    parameter int K        = 10,
    parameter int ID_W     = 6,
    parameter int MAX_ITER = 400,
    parameter int EPS      = 2,
    parameter int STABLE   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 iter_tick,
    input  logic [M*WIDTH-1:0]   node_vals,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [15:0]          iter_count,
    output logic [K*WIDTH-1:0]   topk_vals,
    output logic [K*ID_W-1:0]    topk_ids
);

    localparam int               c_STAB_W = $clog2(STABLE + 1);
    localparam logic [WIDTH-1:0] c_EPS    = WIDTH'(EPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SORT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [WIDTH-1:0]      r_snap [M];
    logic                  r_snap_valid;
    logic [c_STAB_W-1:0]   r_stable;
    logic [15:0]           r_iter_count;
    logic                  r_converged;
    logic [ID_W-1:0]       r_sort_idx;

    logic [WIDTH-1:0]      r_list_val [K];
    logic [ID_W-1:0]       r_list_id  [K];
    logic [K-1:0]          r_list_vld;

    logic [M-1:0]          w_close;
    logic                  w_all_close;
    logic [c_STAB_W-1:0]   w_stable_next;
    logic [15:0]           w_iter_next;
    logic                  w_conv_hit;
    logic                  w_cap_hit;
    logic                  w_run_exit;
    logic                  w_sort_last;
    logic                  w_start_run;

    logic [WIDTH-1:0]      w_ins_val;
    logic [K-1:0]          w_qual;
    logic [WIDTH-1:0]      w_nxt_val [K];
    logic [ID_W-1:0]       w_nxt_id  [K];
    logic [K-1:0]          w_nxt_vld;

    // Per-node convergence test against the stored snapshot
    for (genvar j = 0; j < M; j++) begin : g_close
        logic [WIDTH-1:0] w_new;
        logic [WIDTH-1:0] w_absd;
        assign w_new      = node_vals[j*WIDTH +: WIDTH];
        assign w_absd     = (w_new >= r_snap[j]) ? (w_new - r_snap[j]) : (r_snap[j] - w_new);
        assign w_close[j] = (w_absd <= c_EPS);
    end

    assign w_all_close   = r_snap_valid & (&w_close);
    assign w_stable_next = w_all_close ? (r_stable + 1'b1) : '0;
    assign w_iter_next   = (r_iter_count == 16'hFFFF) ? r_iter_count : (r_iter_count + 16'd1);
    assign w_conv_hit    = (w_stable_next == c_STAB_W'(STABLE));
    assign w_cap_hit     = (w_iter_next == 16'(MAX_ITER));
    assign w_run_exit    = iter_tick & (w_conv_hit | w_cap_hit);
    assign w_sort_last   = (r_sort_idx == ID_W'(M - 1));
    assign w_start_run   = start & ((r_state == S_IDLE) | (r_state == S_DONE));

    // Insertion of one snapshot entry into the ranked list. The list is kept
    // descending with valid slots packed at the top, so the "qualifies" vector
    // is monotone: once a rank qualifies, every lower rank does too. The first
    // qualifying rank takes the new entry and the ones below it shift down.
    assign w_ins_val = r_snap[r_sort_idx];

    for (genvar r = 0; r < K; r++) begin : g_rank
        assign w_qual[r] = ~r_list_vld[r] | (w_ins_val > r_list_val[r]);
        if (r == 0) begin : g_top
            assign w_nxt_val[r] = w_qual[r] ? w_ins_val  : r_list_val[r];
            assign w_nxt_id[r]  = w_qual[r] ? r_sort_idx : r_list_id[r];
            assign w_nxt_vld[r] = w_qual[r] | r_list_vld[r];
        end else begin : g_rest
            logic w_first;
            logic w_shift;
            assign w_first      = w_qual[r] & ~w_qual[r-1];
            assign w_shift      = w_qual[r] &  w_qual[r-1];
            assign w_nxt_val[r] = w_first ? w_ins_val  : (w_shift ? r_list_val[r-1] : r_list_val[r]);
            assign w_nxt_id[r]  = w_first ? r_sort_idx : (w_shift ? r_list_id[r-1]  : r_list_id[r]);
            assign w_nxt_vld[r] = w_first | (w_shift ? r_list_vld[r-1] : r_list_vld[r]);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode and status outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (w_run_exit) w_state_next = S_SORT;
            end
            S_SORT: begin
                busy = 1'b1;
                if (w_sort_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) w_state_next = S_RUN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Iteration counting, convergence tracking and snapshot capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_snap_valid <= 1'b0;
            r_stable     <= '0;
            r_iter_count <= '0;
            r_converged  <= 1'b0;
            r_sort_idx   <= '0;
            for (int j = 0; j < M; j++) r_snap[j] <= '0;
        end else if (w_start_run) begin
            r_snap_valid <= 1'b0;
            r_stable     <= '0;
            r_iter_count <= '0;
            r_converged  <= 1'b0;
            r_sort_idx   <= '0;
        end else if (r_state == S_RUN && iter_tick) begin
            r_iter_count <= w_iter_next;
            r_stable     <= w_stable_next;
            r_snap_valid <= 1'b1;
            for (int j = 0; j < M; j++) r_snap[j] <= node_vals[j*WIDTH +: WIDTH];
            if (w_run_exit) r_converged <= w_conv_hit;
        end else if (r_state == S_SORT) begin
            r_sort_idx <= r_sort_idx + 1'b1;
        end
    end

    // Ranked list: cleared on every new run, updated once per SORT cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_list_vld <= '0;
            for (int r = 0; r < K; r++) begin
                r_list_val[r] <= '0;
                r_list_id[r]  <= '0;
            end
        end else if (w_start_run) begin
            r_list_vld <= '0;
            for (int r = 0; r < K; r++) begin
                r_list_val[r] <= '0;
                r_list_id[r]  <= '0;
            end
        end else if (r_state == S_SORT) begin
            r_list_vld <= w_nxt_vld;
            for (int r = 0; r < K; r++) begin
                r_list_val[r] <= w_nxt_val[r];
                r_list_id[r]  <= w_nxt_id[r];
            end
        end
    end

    assign iter_count = r_iter_count;
    assign converged  = r_converged;

    for (genvar r = 0; r < K; r++) begin : g_out
        assign topk_vals[r*WIDTH +: WIDTH] = r_list_val[r];
        assign topk_ids[r*ID_W +: ID_W]    = r_list_id[r];
    end

endmodule
`default_nettype wire
